// File: rtl/seq_mag_cmp_if.sv
// Handshake and operand/result bundle for seq_mag_cmp.
// master drives start/a/b; slave (the comparator) returns ready/done_tick/flags.
interface seq_mag_cmp_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done_tick;
    logic         gt;
    logic         eq;
    logic         lt;

    modport master (
        output start, a, b,
        input  ready, done_tick, gt, eq, lt
    );

    modport slave (
        input  start, a, b,
        output ready, done_tick, gt, eq, lt
    );
endinterface

// File: rtl/seq_mag_cmp.sv
// Iterative MSB-first magnitude comparator, D bits per cycle, early exit on first differing digit.
// Define SEQ_MAG_CMP_SIGNED_EN to compare two's-complement operands instead of unsigned.
module seq_mag_cmp #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 2
) (
    input logic          clk,
    input logic          reset_n,
    seq_mag_cmp_if.slave bus
);
    localparam int unsigned N  = W / D;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastIdx = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  a_in, b_in;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic [D-1:0]  a_dig, b_dig;
    logic          dig_ne, last_dig;

`ifdef SEQ_MAG_CMP_SIGNED_EN
    // Offset-binary: flipping the sign bit turns a signed compare into an unsigned one.
    localparam logic [W-1:0] SignMask = {1'b1, {(W-1){1'b0}}};
    assign a_in = bus.a ^ SignMask;
    assign b_in = bus.b ^ SignMask;
`else
    assign a_in = bus.a;
    assign b_in = bus.b;
`endif

    assign a_dig    = a_q[W-1 -: D];
    assign b_dig    = b_q[W-1 -: D];
    assign dig_ne   = (a_dig != b_dig);
    assign last_dig = (cnt_q == LastIdx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (dig_ne || last_dig) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.ready     = (state_q == StIdle);
        bus.done_tick = (state_q == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            gt_q  <= gt_d;
            eq_q  <= eq_d;
            lt_q  <= lt_d;
        end
    end

    // Flags only change on the cycle that resolves the compare, so they hold through RUN.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        gt_d  = gt_q;
        eq_d  = eq_q;
        lt_d  = lt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d   = a_in;
                    b_d   = b_in;
                    cnt_d = '0;
                end
            end
            StRun: begin
                if (dig_ne) begin
                    gt_d = (a_dig > b_dig);
                    lt_d = (a_dig < b_dig);
                    eq_d = 1'b0;
                end else if (last_dig) begin
                    gt_d = 1'b0;
                    eq_d = 1'b1;
                    lt_d = 1'b0;
                end else begin
                    a_d   = a_q << D;
                    b_d   = b_q << D;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.gt = gt_q;
    assign bus.eq = eq_q;
    assign bus.lt = lt_q;
endmodule
